// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction; request states stall on MemReady
// with a MEM_WAIT_MAX watchdog. Optional RETIRE_COUNT_EN adds the InstRet retired-instruction counter.
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] OP,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic [1:0] ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [2:0] ULAControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic       Fault
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0] InstRet
`endif
);

    typedef enum logic [3:0] {
        BOOT, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXEC_R, EXEC_I, LUI, ALUWB, BEQ, FAULT
    } state_t;

    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          is_req, wdog_hit, r_legal;

    logic       req_d, mw_d, adr_d, br_d, rw_d, flt_d;
    logic [1:0] sa_d, sb_d, imm_d, res_d;
    logic [2:0] ctl_d;

    // Funct3 to ULAControl; SLTU has no dedicated ULA op and shares SLT
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_op = sub ? 3'b001 : 3'b000;
            3'b001:  alu_op = 3'b110;
            3'b010:  alu_op = 3'b101;
            3'b011:  alu_op = 3'b101;
            3'b100:  alu_op = 3'b100;
            3'b101:  alu_op = 3'b111;
            3'b110:  alu_op = 3'b011;
            default: alu_op = 3'b010;
        endcase
    endfunction

    assign is_req   = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign wdog_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == CW'(MEM_WAIT_MAX));
    assign r_legal  = (Funct7 == 7'b0000000) || (Funct7 == 7'b0100000 && Funct3 == 3'b000);

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:     state_nxt = FETCH;
            FETCH:    if (MemReady) state_nxt = DECODE; else if (wdog_hit) state_nxt = FAULT;
            DECODE: begin
                case (OP)
                    7'b0110011: state_nxt = r_legal ? EXEC_R : FAULT;
                    7'b0010011: state_nxt = EXEC_I;
                    7'b0000011,
                    7'b0100011: state_nxt = (Funct3 == 3'b010) ? MEMADR : FAULT;
                    7'b0110111: state_nxt = LUI;
                    7'b1100011: state_nxt = (Funct3 == 3'b000) ? BEQ : FAULT;
                    default:    state_nxt = FAULT;
                endcase
            end
            MEMADR:   state_nxt = (OP == 7'b0100011) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (MemReady) state_nxt = MEMWB; else if (wdog_hit) state_nxt = FAULT;
            MEMWRITE: if (MemReady) state_nxt = FETCH; else if (wdog_hit) state_nxt = FAULT;
            MEMWB, ALUWB, BEQ: state_nxt = FETCH;
            EXEC_R, EXEC_I, LUI: state_nxt = ALUWB;
            default:  state_nxt = FAULT;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops
    always_comb begin
        req_d = 1'b0; mw_d = 1'b0; adr_d = 1'b0; br_d = 1'b0; rw_d = 1'b0; flt_d = 1'b0;
        sa_d = 2'b00; sb_d = 2'b00; imm_d = 2'b00; res_d = 2'b00; ctl_d = 3'b000;
        case (state_nxt)
            FETCH:    begin req_d = 1'b1; sb_d = 2'b10; res_d = 2'b10; end
            DECODE:   begin sa_d = 2'b01; sb_d = 2'b01; imm_d = 2'b10; end
            MEMADR:   begin sa_d = 2'b10; sb_d = 2'b01; imm_d = (OP == 7'b0100011) ? 2'b01 : 2'b00; end
            MEMREAD:  begin req_d = 1'b1; adr_d = 1'b1; end
            MEMWB:    begin res_d = 2'b01; rw_d = 1'b1; end
            MEMWRITE: begin req_d = 1'b1; mw_d = 1'b1; adr_d = 1'b1; end
            EXEC_R:   begin sa_d = 2'b10; ctl_d = alu_op(Funct3, Funct7[5]); end
            EXEC_I:   begin sa_d = 2'b10; sb_d = 2'b01; ctl_d = alu_op(Funct3, 1'b0); end
            LUI:      begin sa_d = 2'b11; sb_d = 2'b01; imm_d = 2'b11; end
            ALUWB:    rw_d = 1'b1;
            BEQ:      begin sa_d = 2'b10; ctl_d = 3'b001; br_d = 1'b1; end
            FAULT:    flt_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT; wait_cnt <= '0;
            MemReq <= 1'b0; MemWrite <= 1'b0; AdrSrc <= 1'b0; Branch <= 1'b0;
            RegWrite <= 1'b0; Fault <= 1'b0; ULASrcA <= 2'b00; ULASrcB <= 2'b00;
            ImmSrc <= 2'b00; ResultSrc <= 2'b00; ULAControl <= 3'b000;
        end else begin
            state <= state_nxt;
            // Counts only while a request keeps waiting; any state change clears it
            if (is_req && !MemReady && state_nxt == state) wait_cnt <= wait_cnt + 1'b1;
            else                                           wait_cnt <= '0;
            MemReq <= req_d; MemWrite <= mw_d; AdrSrc <= adr_d; Branch <= br_d;
            RegWrite <= rw_d; Fault <= flt_d; ULASrcA <= sa_d; ULASrcB <= sb_d;
            ImmSrc <= imm_d; ResultSrc <= res_d; ULAControl <= ctl_d;
        end
    end

    assign IRWrite  = (state == FETCH) && MemReady;
    assign PCUpdate = (state == FETCH) && MemReady;

`ifdef RETIRE_COUNT_EN
    logic [31:0] instret_q;
    logic        retire;
    assign retire = ((state == MEMWB) || (state == MEMWRITE) || (state == ALUWB) || (state == BEQ))
                    && (state_nxt == FETCH);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret_q <= 32'd0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end
    assign InstRet = instret_q;
`endif

endmodule
